// File: rtl/memory_read_responder.sv
// Pipelined read responder in front of a word array: reads return LATENCY cycles after issue,
// in order, with no backpressure; writes update the array in one cycle and produce no response.
module memory_read_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 11,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [3:0]            outstanding,
  output logic                  idle
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned Last  = LATENCY - 1;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [LATENCY-1:0]    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [LATENCY];
  logic [ADDR_WIDTH-1:0] addr_d [LATENCY];
  logic [DATA_WIDTH-1:0] data_q [LATENCY];
  logic [DATA_WIDTH-1:0] data_d [LATENCY];
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [3:0]            outstanding_q, outstanding_d;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  issue_rd;
  logic                  unused_addr_lsb;

  assign word_idx        = addr[DEPTH_LOG2:1];
  assign issue_rd        = enable & ~wr;
  assign unused_addr_lsb = addr[0];

  // Array is deliberately not reset; writes presented during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst && enable && wr) begin
      mem_q[word_idx] <= data_in;
    end
  end

  // Read data is captured at issue, so later writes cannot affect an in-flight read.
  always_comb begin
    valid_d    = {valid_q[LATENCY-1:0], issue_rd};
    addr_d[0]  = {addr[ADDR_WIDTH-1:1], 1'b0};
    data_d[0]  = mem_q[word_idx];
    for (int i = 1; i < LATENCY; i++) begin
      addr_d[i] = addr_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_comb begin
    hold_data_d   = hold_data_q;
    hold_addr_d   = hold_addr_q;
    outstanding_d = outstanding_q;
    if (valid_q[Last]) begin
      hold_data_d = data_q[Last];
      hold_addr_d = addr_q[Last];
    end
    if (issue_rd && !valid_q[Last]) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!issue_rd && valid_q[Last]) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      hold_data_q   <= '0;
      hold_addr_q   <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      hold_data_q   <= hold_data_d;
      hold_addr_q   <= hold_addr_d;
      outstanding_q <= outstanding_d;
      for (int i = 0; i < LATENCY; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Outputs hold the last response between pulses instead of following the pipeline.
  assign data_valid  = valid_q[Last];
  assign data_out    = data_valid ? data_q[Last] : hold_data_q;
  assign data_addr   = data_valid ? addr_q[Last] : hold_addr_q;
  assign outstanding = outstanding_q;
  assign idle        = (outstanding_q == 4'd0);

endmodule

// File: tb/tb_memory_read_responder.sv
// Self-checking bench for memory_read_responder: directed vector table, hand-written
// corner-case sequences, and random traffic against a queue-based reference model.
module tb_memory_read_responder;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0, enable = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out, data_addr;
  logic        data_valid, idle;
  logic [3:0]  outstanding;

  memory_read_responder #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH_LOG2(11), .LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .data_addr(data_addr),
    .outstanding(outstanding), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] a;
    logic [15:0] d;
    bit          k;
  } rsp_t;

  typedef struct {
    bit          r, e, w;
    logic [15:0] a, d;
    bit          dv;
    logic [15:0] dout, da;
    logic [3:0]  outs;
  } vec_t;

  int          nvec = 0, nfail = 0, cyc = 0, peak = 0;
  logic [15:0] mem [2048];
  bit          known [2048];
  rsp_t        q [$];
  logic [15:0] obs_d [$];
  logic [15:0] obs_a [$];
  int          obs_c [$];
  logic [15:0] last_out = '0;
  bit          last_known = 1'b0;
  vec_t        tbl [8];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare outputs just after the edge.
  task automatic step(bit r, bit e, bit w, logic [15:0] a, logic [15:0] d);
    int idx;
    bit exp_dv;
    int exp_outs;
    rst = r; enable = e; wr = w; addr = a; data_in = d;
    @(posedge clk);
    #1;
    cyc++;
    idx = int'(a[11:1]);
    if (r) begin
      q.delete();
      last_out   = '0;
      last_known = 1'b1;
    end else if (e && w) begin
      mem[idx]   = d;
      known[idx] = 1'b1;
    end else if (e) begin
      q.push_back('{cyc - 1 + L, {a[15:1], 1'b0}, mem[idx], known[idx]});
    end
    exp_outs = q.size();
    exp_dv   = (q.size() > 0) && (q[0].due == cyc);
    check("data_valid", 32'(data_valid), 32'(exp_dv));
    check("outstanding", 32'(outstanding), 32'(exp_outs));
    check("idle", 32'(idle), 32'(exp_outs == 0));
    if (exp_dv) begin
      check("data_addr", 32'(data_addr), 32'(q[0].a));
      if (q[0].k) check("data_out", 32'(data_out), 32'(q[0].d));
      last_out   = q[0].d;
      last_known = q[0].k;
      void'(q.pop_front());
    end else if (last_known) begin
      check("data_out_hold", 32'(data_out), 32'(last_out));
    end
    if (data_valid) begin
      obs_d.push_back(data_out);
      obs_a.push_back(data_addr);
      obs_c.push_back(cyc);
    end
    if (int'(outstanding) > peak) peak = int'(outstanding);
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_a.delete(); obs_c.delete(); peak = 0;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) known[i] = 1'b0;

    // Reset, then write 0x1230 and read it back on the next cycle.
    tbl[0] = '{1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 4'd0};
    tbl[1] = '{1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 4'd0};
    tbl[2] = '{0, 1, 1, 16'h1230, 16'hBEEF, 0, 16'h0000, 16'h0000, 4'd0};
    tbl[3] = '{0, 1, 0, 16'h1230, 16'h0000, 0, 16'h0000, 16'h0000, 4'd1};
    tbl[4] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 4'd1};
    tbl[5] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 4'd1};
    tbl[6] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 16'h1230, 4'd1};
    tbl[7] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 16'h1230, 4'd0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].d);
      check("tbl_valid", 32'(data_valid), 32'(tbl[i].dv));
      check("tbl_dout", 32'(data_out), 32'(tbl[i].dout));
      check("tbl_outs", 32'(outstanding), 32'(tbl[i].outs));
      if (tbl[i].dv) check("tbl_daddr", 32'(data_addr), 32'(tbl[i].da));
    end

    // Fill burst of 8 back-to-back reads.
    for (int i = 0; i < 8; i++) step(0, 1, 1, 16'(16'h4000 + 2 * i), 16'(16'hC000 + i));
    clear_obs();
    for (int i = 0; i < 8; i++) step(0, 1, 0, 16'(16'h4000 + 2 * i), 16'h0);
    for (int i = 0; i < 12 && !idle; i++) step(0, 0, 0, 16'h0, 16'h0);
    check("burst_count", 32'(obs_d.size()), 32'd8);
    check("burst_peak", 32'(peak), 32'(L));
    check("burst_idle", 32'(idle), 32'd1);
    if (obs_d.size() == 8) begin
      check("burst_contig", 32'(obs_c[7] - obs_c[0]), 32'd7);
      for (int i = 0; i < 8; i++) begin
        check("burst_data", 32'(obs_d[i]), 32'(16'hC000 + i));
        check("burst_addr", 32'(obs_a[i]), 32'(16'h4000 + 2 * i));
      end
    end

    // Read/write ordering hazard on one word.
    step(0, 1, 1, 16'h0010, 16'h1111);
    clear_obs();
    step(0, 1, 0, 16'h0010, 16'h0);
    step(0, 1, 1, 16'h0010, 16'h2222);
    step(0, 1, 0, 16'h0010, 16'h0);
    idle_cycles(L + 2);
    check("hazard_count", 32'(obs_d.size()), 32'd2);
    if (obs_d.size() == 2) begin
      check("hazard_old", 32'(obs_d[0]), 32'h1111);
      check("hazard_new", 32'(obs_d[1]), 32'h2222);
    end

    // Upper address bits alias onto the same word.
    step(0, 1, 1, 16'h0002, 16'hA5A5);
    clear_obs();
    step(0, 1, 0, 16'h1002, 16'h0);
    idle_cycles(L + 1);
    check("alias_count", 32'(obs_d.size()), 32'd1);
    if (obs_d.size() == 1) begin
      check("alias_data", 32'(obs_d[0]), 32'hA5A5);
      check("alias_addr", 32'(obs_a[0]), 32'h1002);
    end

    // Reset mid-burst discards in-flight reads and a concurrent write.
    step(0, 1, 1, 16'h0020, 16'h7777);
    clear_obs();
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'(16'h0020 + 2 * i), 16'h0);
    step(1, 1, 1, 16'h0020, 16'hDEAD);
    idle_cycles(L + 3);
    check("rst_pulses", 32'(obs_d.size()), 32'd0);
    check("rst_outs", 32'(outstanding), 32'd0);
    step(0, 1, 0, 16'h0020, 16'h0);
    idle_cycles(L + 1);
    check("rst_after_count", 32'(obs_d.size()), 32'd1);
    if (obs_d.size() == 1) check("rst_after_data", 32'(obs_d[0]), 32'h7777);

    // Random traffic over a small, aliased window so reads hit written words.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = 16'(16'h0100 + 2 * $urandom_range(0, 15));
      a[15:12] = 4'($urandom);
      a[0] = 1'($urandom);
      step(($urandom_range(0, 39) == 0), 1'($urandom), ($urandom_range(0, 2) == 0), a,
           16'($urandom));
    end
    idle_cycles(L + 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
